vx_commit_arb: RTL and testbench

- Downstream neighbour of the execute stage. Per issue slot, it merges the commit streams of the ALU, LSU, SFU and FPU units into one commit stream for writeback/retire.
- Round-robin arbitration with packet locking: a multi-beat commit (sop..eop) from one unit is never interleaved with another unit's commit.
- Output is registered through a 2-entry elastic buffer, so full throughput is sustained and out_ready has no combinational path to the unit ready signals.

---
 rtl/vx_commit_arb_pkg.sv | 21 ++
 rtl/vx_commit_rr_sel.sv | 30 +++
 rtl/vx_commit_arb.sv | 164 ++++++++++++++++
 tb/tb_vx_commit_arb.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vx_commit_arb_pkg.sv
// Shared types for the commit arbiter: per-beat commit payload and the unit index map.
package vx_commit_arb_pkg;

    localparam int unsigned COMMIT_DATA_W   = 128;
    localparam int unsigned COMMIT_NUM_SRCS = 4;
    localparam int unsigned COMMIT_CNT_W    = 32;

    typedef enum logic [1:0] {
        COMMIT_SRC_ALU = 2'd0,
        COMMIT_SRC_LSU = 2'd1,
        COMMIT_SRC_SFU = 2'd2,
        COMMIT_SRC_FPU = 2'd3
    } commit_src_e;

    typedef struct packed {
        logic [COMMIT_DATA_W-1:0] data;
        logic                     sop;
        logic                     eop;
    } commit_pkt_t;

endpackage

// File: rtl/vx_commit_rr_sel.sv
// Combinational cyclic priority select: first valid source at or after rr_ptr.
module vx_commit_rr_sel #(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0]         valid,
    input  logic [$clog2(N)-1:0] rr_ptr,
    output logic [N-1:0]         grant_oh,
    output logic [$clog2(N)-1:0] grant_idx,
    output logic                 any
);

    localparam int unsigned IDX_W = $clog2(N);

    always_comb begin
        int unsigned j;
        grant_oh  = '0;
        grant_idx = '0;
        any       = 1'b0;
        j         = 0;
        for (int unsigned k = 0; k < N; k++) begin
            j = (32'(rr_ptr) + k) % N;
            if (!any && valid[j]) begin
                any         = 1'b1;
                grant_idx   = IDX_W'(j);
                grant_oh[j] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/vx_commit_arb.sv
// Merges per-unit commit streams into one, round-robin with packet locking, via a 2-entry output buffer.
// Optional perf counters (perf_commits, perf_stalls) are built when VX_COMMIT_ARB_PERF_EN is defined.
module vx_commit_arb
    import vx_commit_arb_pkg::*;
#(
    parameter int unsigned NUM_SRCS = COMMIT_NUM_SRCS,
    parameter int unsigned DATA_W   = COMMIT_DATA_W,
    parameter int unsigned CNT_W    = COMMIT_CNT_W
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_SRCS-1:0]          in_valid,
    input  logic [NUM_SRCS*DATA_W-1:0]   in_data,
    input  logic [NUM_SRCS-1:0]          in_sop,
    input  logic [NUM_SRCS-1:0]          in_eop,
    output logic [NUM_SRCS-1:0]          in_ready,
    output logic                         out_valid,
    output logic [DATA_W-1:0]            out_data,
    output logic                         out_sop,
    output logic                         out_eop,
    output logic [$clog2(NUM_SRCS)-1:0]  out_src,
    input  logic                         out_ready
`ifdef VX_COMMIT_ARB_PERF_EN
    ,
    output logic [CNT_W-1:0]             perf_commits,
    output logic [CNT_W-1:0]             perf_stalls
`endif
);

    localparam int unsigned SRC_W = $clog2(NUM_SRCS);

    commit_pkt_t      mem_q   [2];
    commit_pkt_t      mem_d   [2];
    logic [SRC_W-1:0] msrc_q  [2];
    logic [SRC_W-1:0] msrc_d  [2];
    logic             rd_ptr_q, rd_ptr_d;
    logic             wr_ptr_q, wr_ptr_d;
    logic [1:0]       count_q, count_d;
    logic             lock_q, lock_d;
    logic [SRC_W-1:0] locked_src_q, locked_src_d;
    logic [SRC_W-1:0] rr_ptr_q, rr_ptr_d;

    logic [NUM_SRCS-1:0] sel_oh, gnt_oh;
    logic [SRC_W-1:0]    sel_idx, gnt_idx;
    logic                sel_any;
    logic                acc, pop;
    commit_pkt_t         beat;

    vx_commit_rr_sel #(.N(NUM_SRCS)) u_rr_sel (
        .valid     (in_valid),
        .rr_ptr    (rr_ptr_q),
        .grant_oh  (sel_oh),
        .grant_idx (sel_idx),
        .any       (sel_any)
    );

    // Grant: a held lock overrides round-robin; readiness looks only at buffer occupancy.
    always_comb begin
        gnt_oh  = '0;
        gnt_idx = lock_q ? locked_src_q : sel_idx;
        if (lock_q) begin
            gnt_oh[locked_src_q] = 1'b1;
        end else if (sel_any) begin
            gnt_oh = sel_oh;
        end
        in_ready = (!reset && count_q != 2'd2) ? gnt_oh : '0;
    end

    always_comb begin
        beat.data = in_data[32'(gnt_idx)*DATA_W +: DATA_W];
        beat.sop  = in_sop[gnt_idx];
        beat.eop  = in_eop[gnt_idx];
        acc       = |(in_valid & in_ready);
        pop       = (count_q != 2'd0) && out_ready;
    end

    always_comb begin
        mem_d    = mem_q;
        msrc_d   = msrc_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (acc) begin
            mem_d[wr_ptr_q]  = beat;
            msrc_d[wr_ptr_q] = gnt_idx;
            wr_ptr_d         = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        count_d = count_q + 2'(acc) - 2'(pop);
    end

    // Lock opens on sop-without-eop, closes on any eop from the locked unit.
    always_comb begin
        lock_d       = lock_q;
        locked_src_d = locked_src_q;
        rr_ptr_d     = rr_ptr_q;
        if (acc) begin
            if (beat.sop && !beat.eop) begin
                lock_d       = 1'b1;
                locked_src_d = gnt_idx;
            end else if (beat.eop && lock_q && gnt_idx == locked_src_q) begin
                lock_d = 1'b0;
            end
            if (beat.eop) begin
                rr_ptr_d = SRC_W'((32'(gnt_idx) + 1) % NUM_SRCS);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 2; i++) begin
                mem_q[i]  <= '0;
                msrc_q[i] <= '0;
            end
            rd_ptr_q     <= 1'b0;
            wr_ptr_q     <= 1'b0;
            count_q      <= 2'd0;
            lock_q       <= 1'b0;
            locked_src_q <= '0;
            rr_ptr_q     <= '0;
        end else begin
            mem_q        <= mem_d;
            msrc_q       <= msrc_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            count_q      <= count_d;
            lock_q       <= lock_d;
            locked_src_q <= locked_src_d;
            rr_ptr_q     <= rr_ptr_d;
        end
    end

    assign out_valid = (count_q != 2'd0);
    assign out_data  = mem_q[rd_ptr_q].data;
    assign out_sop   = mem_q[rd_ptr_q].sop;
    assign out_eop   = mem_q[rd_ptr_q].eop;
    assign out_src   = msrc_q[rd_ptr_q];

`ifdef VX_COMMIT_ARB_PERF_EN
    logic [CNT_W-1:0] commits_q, commits_d;
    logic [CNT_W-1:0] stalls_q, stalls_d;

    always_comb begin
        commits_d = commits_q + CNT_W'(pop && out_eop);
        stalls_d  = stalls_q + CNT_W'((count_q != 2'd0) && !out_ready);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            commits_q <= '0;
            stalls_q  <= '0;
        end else begin
            commits_q <= commits_d;
            stalls_q  <= stalls_d;
        end
    end

    assign perf_commits = commits_q;
    assign perf_stalls  = stalls_q;
`endif

endmodule

// File: tb/tb_vx_commit_arb.sv
// Scoreboard bench for vx_commit_arb: directed scenarios followed by random valid/ready traffic.
module tb_vx_commit_arb;
    import vx_commit_arb_pkg::*;

    localparam int unsigned N  = 4;
    localparam int unsigned DW = 128;
    localparam int unsigned CW = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    in_valid, in_sop, in_eop, in_ready;
    logic [N*DW-1:0] in_data;
    logic            out_valid, out_sop, out_eop, out_ready;
    logic [DW-1:0]   out_data;
    logic [1:0]      out_src;
`ifdef VX_COMMIT_ARB_PERF_EN
    logic [CW-1:0]   perf_commits, perf_stalls;
`endif

    vx_commit_arb dut (
        .clk       (clk),
        .reset     (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_sop    (in_sop),
        .in_eop    (in_eop),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_sop   (out_sop),
        .out_eop   (out_eop),
        .out_src   (out_src),
        .out_ready (out_ready)
`ifdef VX_COMMIT_ARB_PERF_EN
        ,
        .perf_commits (perf_commits),
        .perf_stalls  (perf_stalls)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] data;
        logic          sop;
        logic          eop;
        int unsigned   src;
    } beat_t;

    beat_t        exp_q[$];
    int           checks   = 0;
    int           failures = 0;
    int unsigned  m_cnt = 0, m_rr = 0, m_locked = 0;
    bit           m_lock = 1'b0;
    int unsigned  m_commits = 0, m_stalls = 0;
    int unsigned  out_beats = 0;
    logic [N-1:0] acc_vec = '0;
    bit           rand_mode = 1'b0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
        end
    endtask

    // Which source the arbiter must be offering this cycle, from the spec rules.
    function automatic logic [N-1:0] exp_ready();
        logic [N-1:0] r;
        r = '0;
        if (m_cnt >= 2) return r;
        if (m_lock) begin
            r[m_locked] = 1'b1;
            return r;
        end
        for (int unsigned k = 0; k < N; k++) begin
            if (in_valid[(m_rr + k) % N]) begin
                r[(m_rr + k) % N] = 1'b1;
                return r;
            end
        end
        return r;
    endfunction

    // Predictor: checks handshake signals, queues accepted beats, advances the model.
    always @(negedge clk) begin
        logic [N-1:0] er;
        bit           pop;
        beat_t        b;
        if (rst) begin
            exp_q.delete();
            m_cnt = 0; m_rr = 0; m_lock = 1'b0; m_locked = 0;
            m_commits = 0; m_stalls = 0;
            acc_vec = '0;
            chk("rst_in_ready", 128'(in_ready), 128'(0));
            chk("rst_out_valid", 128'(out_valid), 128'(0));
        end else begin
            er = exp_ready();
            chk("in_ready", 128'(in_ready), 128'(er));
            chk("out_valid", 128'(out_valid), 128'(m_cnt != 0));
            pop = (m_cnt != 0) && out_ready;
            if ((m_cnt != 0) && !out_ready) m_stalls++;
            if (pop && exp_q.size() > 0 && exp_q[0].eop) m_commits++;
            acc_vec = in_valid & er;
            for (int unsigned i = 0; i < N; i++) begin
                if (acc_vec[i]) begin
                    b.data = in_data[i*DW +: DW];
                    b.sop  = in_sop[i];
                    b.eop  = in_eop[i];
                    b.src  = i;
                    exp_q.push_back(b);
                    if (b.sop && !b.eop) begin
                        m_lock = 1'b1; m_locked = i;
                    end else if (b.eop && m_lock && m_locked == i) begin
                        m_lock = 1'b0;
                    end
                    if (b.eop) m_rr = (i + 1) % N;
                end
            end
            m_cnt = m_cnt + ((acc_vec != '0) ? 1 : 0) - (pop ? 1 : 0);
        end
    end

    // Monitor: pops the expected beat whenever the DUT hands one downstream.
    always @(negedge clk) begin
        beat_t       b;
        bit          in_pkt;
        int unsigned pkt_src;
        #1;
        if (rst) begin
            in_pkt = 1'b0;
            pkt_src = 0;
        end else if (out_valid && out_ready) begin
            out_beats++;
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL out_unexpected actual=beat src %0d required=no beat t=%0t", out_src, $time);
            end else begin
                b = exp_q.pop_front();
                chk("out_data", 128'(out_data), 128'(b.data));
                chk("out_sop", 128'(out_sop), 128'(b.sop));
                chk("out_eop", 128'(out_eop), 128'(b.eop));
                chk("out_src", 128'(out_src), 128'(b.src));
                if (in_pkt) chk("no_interleave", 128'(out_src), 128'(pkt_src));
                if (out_sop && !out_eop) begin
                    in_pkt = 1'b1;
                    pkt_src = 32'(out_src);
                end else if (out_eop) begin
                    in_pkt = 1'b0;
                end
            end
        end
    end

    // Random driver: each source plays 1..3 beat packets, holding a beat until accepted.
    int unsigned r_len[N], r_pos[N];
    bit          r_pres[N];
    always @(posedge clk) begin
        #1;
        if (rand_mode) begin
            for (int unsigned i = 0; i < N; i++) begin
                if (acc_vec[i]) begin
                    r_pres[i] = 1'b0;
                    r_pos[i]++;
                    if (r_pos[i] == r_len[i]) begin
                        r_pos[i] = 0;
                        r_len[i] = 0;
                    end
                end
                if (!r_pres[i]) begin
                    if (r_len[i] == 0 && $urandom_range(0, 3) == 0) begin
                        r_len[i] = $urandom_range(1, 3);
                        r_pos[i] = 0;
                    end
                    if (r_len[i] != 0 && $urandom_range(0, 3) != 0) begin
                        r_pres[i] = 1'b1;
                        in_data[i*DW +: DW] = {$urandom, $urandom, $urandom, $urandom};
                    end
                end
                in_valid[i] = r_pres[i];
                in_sop[i]   = (r_pos[i] == 0);
                in_eop[i]   = (r_pos[i] + 1 == r_len[i]);
            end
            out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    task automatic idle_inputs();
        in_valid = '0;
        in_sop   = '0;
        in_eop   = '0;
    endtask

    // Waits (bounded) until the bench model records acceptance of source s.
    task automatic wait_acc(input int unsigned s);
        int t;
        t = 0;
        forever begin
            @(negedge clk); #2;
            if (acc_vec[s]) break;
            t++;
            if (t > 20) begin
                checks++;
                failures++;
                $display("FAIL wait_acc_timeout actual=no accept required=accept src %0d", s);
                break;
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        int unsigned b0;
        for (int i = 0; i < int'(N); i++) begin
            r_len[i] = 0; r_pos[i] = 0; r_pres[i] = 1'b0;
        end
        rst = 1'b1;
        in_data = '0;
        idle_inputs();
        out_ready = 1'b1;

        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk); #2;
        chk("rst_out_data", 128'(out_data), 128'(0));
        chk("rst_out_src", 128'(out_src), 128'(0));
        chk("rst_out_sop_eop", 128'({out_sop, out_eop}), 128'(0));

        // Single ALU beat: visible one cycle after acceptance.
        @(posedge clk); #1;
        rst = 1'b0;
        in_valid[COMMIT_SRC_ALU] = 1'b1;
        in_sop[COMMIT_SRC_ALU]   = 1'b1;
        in_eop[COMMIT_SRC_ALU]   = 1'b1;
        in_data[0 +: DW]         = 128'hA5;
        @(posedge clk); #1;
        idle_inputs();
        @(negedge clk); #2;
        chk("t1_out_valid", 128'(out_valid), 128'(1));
        chk("t1_out_data", 128'(out_data), 128'hA5);
        chk("t1_out_src", 128'(out_src), 128'(COMMIT_SRC_ALU));

        // All sources streaming single-beat packets: one output per cycle.
        @(posedge clk); #1;
        b0 = out_beats;
        for (int c = 0; c < 12; c++) begin
            in_valid = '1; in_sop = '1; in_eop = '1;
            for (int i = 0; i < int'(N); i++) in_data[i*DW +: DW] = {$urandom, $urandom, $urandom, $urandom};
            @(posedge clk); #1;
        end
        idle_inputs();
        @(negedge clk); #2;
        chk("t2_beats", 128'(out_beats - b0), 128'(12));

        // LSU 3-beat packet while ALU keeps requesting: ALU blocked mid-packet.
        @(posedge clk); #1;
        for (int unsigned b = 0; b < 3; b++) begin
            in_valid[COMMIT_SRC_ALU] = 1'b1; in_sop[COMMIT_SRC_ALU] = 1'b1; in_eop[COMMIT_SRC_ALU] = 1'b1;
            in_valid[COMMIT_SRC_LSU] = 1'b1;
            in_sop[COMMIT_SRC_LSU]   = (b == 0);
            in_eop[COMMIT_SRC_LSU]   = (b == 2);
            in_data[COMMIT_SRC_LSU*DW +: DW] = 128'(32'h1500 + b);
            wait_acc(COMMIT_SRC_LSU);
            if (b > 0) chk("t3_alu_blocked", 128'(in_ready[COMMIT_SRC_ALU]), 128'(0));
            @(posedge clk); #1;
        end
        in_valid[COMMIT_SRC_LSU] = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        idle_inputs();
        repeat (3) @(posedge clk);

        // Backpressure: SFU fills the buffer, then is refused.
        #1;
        out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            in_valid[COMMIT_SRC_SFU] = 1'b1; in_sop[COMMIT_SRC_SFU] = 1'b1; in_eop[COMMIT_SRC_SFU] = 1'b1;
            in_data[COMMIT_SRC_SFU*DW +: DW] = {$urandom, $urandom, $urandom, $urandom};
            @(posedge clk); #1;
        end
        chk("t4_full_in_ready", 128'(in_ready), 128'(0));
        chk("t4_full_out_valid", 128'(out_valid), 128'(1));
`ifdef VX_COMMIT_ARB_PERF_EN
        chk("t4_perf_stalls", 128'(perf_stalls), 128'(m_stalls));
`endif
        idle_inputs();
        out_ready = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk); #2;
        chk("t4_drained", 128'(exp_q.size()), 128'(0));

        // Reset while locked with one beat buffered.
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid[COMMIT_SRC_LSU] = 1'b1; in_sop[COMMIT_SRC_LSU] = 1'b1; in_eop[COMMIT_SRC_LSU] = 1'b0;
        @(posedge clk); #1;
        idle_inputs();
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("t5_rst_out_valid", 128'(out_valid), 128'(0));
        chk("t5_rst_in_ready", 128'(in_ready), 128'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        out_ready = 1'b1;
        in_valid[COMMIT_SRC_FPU] = 1'b1; in_sop[COMMIT_SRC_FPU] = 1'b1; in_eop[COMMIT_SRC_FPU] = 1'b1;
        in_data[COMMIT_SRC_FPU*DW +: DW] = 128'hF00D;
        @(negedge clk); #2;
        chk("t5_fpu_granted", 128'(in_ready), 128'(4'b1000));
        @(posedge clk); #1;
        idle_inputs();
        @(negedge clk); #2;
        chk("t5_fpu_out", 128'(out_data), 128'hF00D);

        // Random traffic.
        @(posedge clk);
        rand_mode = 1'b1;
        repeat (10000) @(posedge clk);
        rand_mode = 1'b0;
        #1;
        idle_inputs();
        out_ready = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("rand_drained", 128'(exp_q.size()), 128'(0));
`ifdef VX_COMMIT_ARB_PERF_EN
        chk("perf_commits", 128'(perf_commits), 128'(m_commits));
        chk("perf_stalls", 128'(perf_stalls), 128'(m_stalls));
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

endmodule
